// File: rtl/key_edge_bank.sv
// key_edge_bank: multi-channel push-button front end.
// Each channel runs through a reset-to-1 synchroniser and a stability-counter
// debouncer, then emits a one-cycle pulse on the edge picked by edge_mode.
// Optional auto-repeat for held keys is built when KEY_AUTOREPEAT_EN is defined.
// Keys idle high and read low while pressed.

module key_edge_bank #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int REP_DELAY   = 50000000,
  parameter int REP_PERIOD  = 10000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] key,
  input  logic [1:0]    edge_mode,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pulse,
  output logic          any_pulse
);

  // Debounce counter only has to reach DB_CYCLES-1.
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_FALL = 2'b00,
    MODE_RISE = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } edge_mode_e;

  edge_mode_e mode;
  logic       want_press;
  logic       want_release;

  assign mode         = edge_mode_e'(edge_mode);
  assign want_press   = (mode == MODE_FALL) || (mode == MODE_BOTH);
  assign want_release = (mode == MODE_RISE) || (mode == MODE_BOTH);

  // Stage 0 is the LSB and takes the raw key; the MSB is the synchronised level.
  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [SYNC_STAGES-1:0] sync_d [CH];
  logic [CH-1:0]          sync_s;

  logic [DB_W-1:0] db_cnt_q [CH];
  logic [DB_W-1:0] db_cnt_d [CH];
  logic [CH-1:0]   level_q, level_d;
  logic [CH-1:0]   pulse_q, pulse_d;
  logic            any_pulse_q, any_pulse_d;

  // Commit events of this cycle, split by direction.
  logic [CH-1:0] commit_press;
  logic [CH-1:0] commit_release;
  logic [CH-1:0] rep_fire;

  // Shift every channel's synchroniser by one stage.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], key[i]};
      sync_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce: count consecutive cycles that disagree with the accepted level,
  // accept the new level when the count completes, restart on any agreement.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    level_d        = level_q;
    commit_press   = '0;
    commit_release = '0;
    for (int i = 0; i < CH; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_s[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]       = '0;
        level_d[i]        = sync_s[i];
        commit_press[i]   = ~sync_s[i];
        commit_release[i] = sync_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Repeat counter counts cycles since the press commit (first interval) or
  // since the previous repeat pulse (later intervals).
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REP_PERIOD);

  logic [REP_W-1:0] rep_cnt_q [CH];
  logic [REP_W-1:0] rep_cnt_d [CH];
  logic [CH-1:0]    rep_on_q, rep_on_d;
  logic [CH-1:0]    rep_first_q, rep_first_d;

  // Auto-repeat: armed by a press commit in a press-reporting mode, dropped
  // as soon as the key is released or the mode stops reporting presses.
  always_comb begin
    rep_on_d    = rep_on_q;
    rep_first_d = rep_first_q;
    rep_fire    = '0;
    for (int i = 0; i < CH; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (rep_on_q[i] && !level_q[i] && want_press) begin
        if (rep_first_q[i] && (rep_cnt_q[i] == REP_DELAY_C)) begin
          rep_fire[i]    = 1'b1;
          rep_first_d[i] = 1'b0;
          rep_cnt_d[i]   = REP_W'(1);
        end else if (!rep_first_q[i] && (rep_cnt_q[i] == REP_PERIOD_C)) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = REP_W'(1);
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end else begin
        rep_on_d[i]    = 1'b0;
        rep_first_d[i] = 1'b0;
        rep_cnt_d[i]   = '0;
      end
      // A commit on this edge overrides the running count.
      if (commit_press[i] && want_press) begin
        rep_on_d[i]    = 1'b1;
        rep_first_d[i] = 1'b1;
        rep_cnt_d[i]   = REP_W'(1);
      end else if (commit_release[i]) begin
        rep_on_d[i]    = 1'b0;
        rep_first_d[i] = 1'b0;
        rep_cnt_d[i]   = '0;
      end
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        rep_cnt_q[i] <= '0;
      end
      rep_on_q    <= '0;
      rep_first_q <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_on_q    <= rep_on_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  // Repeat parameters have no effect in this build.
  logic unused_rep_params;
  assign unused_rep_params = ^{32'(REP_DELAY), 32'(REP_PERIOD)};
  assign rep_fire          = '0;
`endif

  // Qualify commits against the mode sampled on the same edge; a repeat
  // landing on a commit edge merges into the same single pulse.
  always_comb begin
    pulse_d     = (commit_press & {CH{want_press}})
                | (commit_release & {CH{want_release}})
                | rep_fire;
    any_pulse_d = |pulse_d;
  end

  // Main state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: register arrays are small per-channel flops, not RAM, so every
      // element is reset explicitly; synchronisers reset to the idle level.
      for (int i = 0; i < CH; i++) begin
        sync_q[i]   <= '1;
        db_cnt_q[i] <= '0;
      end
      level_q     <= '1;
      pulse_q     <= '0;
      any_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      any_pulse_q <= any_pulse_d;
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_key_edge_bank.sv
// Testbench for key_edge_bank: directed scenarios plus random key activity.
// A reference model turns the key history into expected pulses (pushed to a
// queue); a monitor pops and compares whenever the DUT pulses.
// Honours KEY_AUTOREPEAT_EN in the same way as the design.

module tb_key_edge_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] key;
  logic [1:0]    edge_mode;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic          any_pulse;

  always #5 clk = ~clk;

  key_edge_bank #(
    .CH(CH), .SYNC_STAGES(SS), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .edge_mode(edge_mode),
    .level(level), .pulse(pulse), .any_pulse(any_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            cyc;
    logic [CH-1:0] pulse;
  } exp_t;

  exp_t          exp_q[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level = '1;
  bit            armed [CH];
  int            commit_cyc [CH];

  int            pulse_cnt [CH];
  int            last_pulse_cyc [CH];
  logic [CH-1:0] last_vec = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a level is accepted once the last DB synchronised samples
  // all differ from it; synchronised sample at edge t is the key seen at t-SS.
  always @(posedge clk) begin : model
    logic [CH-1:0] p;
    bit            all_diff;
    bit            rep_ok;
    int            n;
    cyc++;
    if (!rst_n) begin
      m_level = '1;
      hist.delete();
      for (int k = 0; k < SS + DB; k++) hist.push_back('1);
      exp_q.delete();
      for (int c = 0; c < CH; c++) armed[c] = 1'b0;
    end else begin
      p = '0;
      rep_ok = (edge_mode == 2'b00) || (edge_mode == 2'b10);
      hist.push_back(key);
      while (hist.size() > SS + DB) void'(hist.pop_front());
      for (int c = 0; c < CH; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (hist[k][c] == m_level[c]) all_diff = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        if (armed[c] && (!rep_ok || m_level[c])) armed[c] = 1'b0;
        if (armed[c]) begin
          n = cyc - commit_cyc[c];
          if (n == RD || (n > RD && ((n - RD) % RP) == 0)) p[c] = 1'b1;
        end
`else
        n = 0;
`endif
        if (all_diff) begin
          if (m_level[c]) begin
            if (rep_ok) begin
              p[c] = 1'b1;
              armed[c] = 1'b1;
              commit_cyc[c] = cyc;
            end
          end else begin
            if (edge_mode == 2'b01 || edge_mode == 2'b10) p[c] = 1'b1;
            armed[c] = 1'b0;
          end
          m_level[c] = ~m_level[c];
        end
      end
      if (p != '0) exp_q.push_back('{cyc: cyc, pulse: p});
    end
  end

  // Monitor: compare level every cycle and match DUT pulses against the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("level", level, m_level);
      if (pulse != '0 || any_pulse) begin
        for (int c = 0; c < CH; c++) begin
          if (pulse[c]) begin
            pulse_cnt[c]++;
            last_pulse_cyc[c] = cyc;
          end
        end
        last_vec = pulse;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {pulse, any_pulse}, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_vec", pulse, e.pulse);
          check("any_pulse", any_pulse, 1);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_pulse", pulse, e.pulse);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, level, 4'hF);
    check({tag, "_pulse"}, pulse, 0);
    check({tag, "_any"}, any_pulse, 0);
  endtask

  initial begin : stim
    int e0;
    int base;
    int cnt_a;
    int hold [CH];
    for (int c = 0; c < CH; c++) begin
      pulse_cnt[c] = 0;
      last_pulse_cyc[c] = -1;
      hold[c] = 0;
    end
    rst_n = 1'b0;
    key = '1;
    edge_mode = 2'b00;
    wait_cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(3);

    // 1: single press in falling mode, pulse at E0+9, other channels quiet.
    key[0] = 1'b0;
    e0 = cyc + 1;
    wait_cycles(15);
    check("s1_pulse_time", last_pulse_cyc[0], e0 + SS + DB - 1);
    check("s1_pulse_cnt", pulse_cnt[0], 1);
    check("s1_level", level[0], 0);
    check("s1_quiet", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    key[0] = 1'b1;
    wait_cycles(15);
    check("s1_release_no_pulse", pulse_cnt[0], 1);

    // 2: a 7-cycle glitch never commits.
    edge_mode = 2'b10;
    key[1] = 1'b0;
    wait_cycles(7);
    key[1] = 1'b1;
    wait_cycles(15);
    check("s2_no_pulse", pulse_cnt[1], 0);
    check("s2_level", level[1], 1);

    // 3: rising mode pulses only on release; mode none only tracks level.
    edge_mode = 2'b01;
    key[2] = 1'b0;
    wait_cycles(15);
    check("s3_press_quiet", pulse_cnt[2], 0);
    check("s3_level_low", level[2], 0);
    key[2] = 1'b1;
    e0 = cyc + 1;
    wait_cycles(15);
    check("s3_release_time", last_pulse_cyc[2], e0 + SS + DB - 1);
    edge_mode = 2'b11;
    key[2] = 1'b0;
    wait_cycles(15);
    check("s3_none_level_low", level[2], 0);
    key[2] = 1'b1;
    wait_cycles(15);
    check("s3_none_level_high", level[2], 1);
    check("s3_pulse_cnt", pulse_cnt[2], 1);

    // 4: simultaneous presses on channels 0 and 3.
    edge_mode = 2'b10;
    key[0] = 1'b0;
    key[3] = 1'b0;
    e0 = cyc + 1;
    wait_cycles(15);
    check("s4_vec", last_vec, 4'b1001);
    check("s4_time0", last_pulse_cyc[0], e0 + SS + DB - 1);
    check("s4_time3", last_pulse_cyc[3], e0 + SS + DB - 1);
    key[0] = 1'b1;
    key[3] = 1'b1;
    wait_cycles(15);

    // 5: reset in the middle of a debounce interval, key kept low.
    edge_mode = 2'b00;
    key[3] = 1'b0;
    wait_cycles(15);
    key[1] = 1'b0;
    wait_cycles(SS + 5);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("s5_mid_reset");
    wait_cycles(2);
    rst_n = 1'b1;
    e0 = cyc + 1;
    wait_cycles(15);
    check("s5_time1", last_pulse_cyc[1], e0 + SS + DB - 1);
    check("s5_time3", last_pulse_cyc[3], e0 + SS + DB - 1);

    // 6: long hold in falling mode (repeats only with auto-repeat built).
    key = '1;
    wait_cycles(15);
    key[0] = 1'b0;
    e0 = cyc + 1;
    base = pulse_cnt[0];
    wait_cycles(SS + DB - 1 + 37);
`ifdef KEY_AUTOREPEAT_EN
    check("s6_hold_cnt", pulse_cnt[0] - base, 5);
    check("s6_last", last_pulse_cyc[0], e0 + SS + DB - 1 + 35);
`else
    check("s6_hold_cnt", pulse_cnt[0] - base, 1);
    check("s6_last", last_pulse_cyc[0], e0 + SS + DB - 1);
`endif
    key[0] = 1'b1;
    wait_cycles(12);
    cnt_a = pulse_cnt[0];
    wait_cycles(30);
    check("s6_repeat_stops", pulse_cnt[0], cnt_a);

    // Random phase: held levels, short glitches and occasional mode changes.
    repeat (3000) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          key[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 40);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 59) == 0) edge_mode = 2'($urandom_range(0, 3));
    end
    key = '1;
    wait_cycles(30);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_edge_bank.md
# key_edge_bank

Multi-channel key front end and parametrised successor to the single-key edge detector. Each channel synchronises a raw key input, debounces it with a stability counter, and emits a one-cycle pulse on a selectable edge. An optional auto-repeat adds periodic pulses while a key is held. It sits between the board push-buttons and the control FSMs, replacing per-key edge detectors.

## Interface
- `CH`, 4: number of independent key channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DB_CYCLES`, 1000000: consecutive stable cycles needed to accept a new level (≥1; 10 ms at 100 MHz).
- `REP_DELAY`, 50000000: cycles from accepted press to the first repeat pulse. Used only with auto-repeat.
- `REP_PERIOD`, 10000000: cycles between later repeat pulses. Used only with auto-repeat.

Ports:
- `clk`, in, 1: single clock; all state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key`, in, CH: raw asynchronous key levels; idle high, pressed low.
- `edge_mode`, in, 2: global edge select.
  - 00: falling (press).
  - 01: rising (release).
  - 10: both.
  - 11: none.
- `level`, out, CH: debounced key levels.
- `pulse`, out, CH: one-cycle event strobes.
- `any_pulse`, out, 1: registered OR of the `pulse` value for the same cycle; asserted in the same cycle as `pulse`.

## Operation
- **Reset values:**
  - All synchroniser flops reset to 1.
  - `level` resets to all 1s.
  - `pulse` and `any_pulse` reset to 0.
  - All counters reset to 0.
- **Synchroniser:** each channel passes through `SYNC_STAGES` flops. Call the last stage `s[i]`.
- **Debounce**, per channel, each edge:
  - If `s[i]==level[i]`: clear the counter.
  - Otherwise, if the counter equals `DB_CYCLES-1`: set `level[i]<=s[i]`, clear the counter, and raise an edge event.
  - Otherwise: increment the counter.
- **Glitch rejection:** any return of `s[i]` to `level[i]` before commit clears the counter, so no event is raised.
- **Counter width:** `$clog2(DB_CYCLES+1)` bits. The counter never exceeds `DB_CYCLES-1`.
- **Pulse qualification:** on the edge-event edge, `pulse[i]<=1` if the event direction matches `edge_mode` as sampled on that same edge. On every other edge, `pulse[i]<=0`.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- **Mode changes:** a change of `edge_mode` affects only events committed afterwards. Missed edges are never replayed.
- **Reset mid-operation:** an asserted `rst_n` immediately clears all state, including partially counted debounce intervals and any pulse in flight. After release, outputs restart from the reset values. Keys held low during reset therefore produce a press event `DB_CYCLES` edges after the synchroniser sees them.

## Timing
- Let E0 be the first edge that samples a stable new `key` value.
- `level[i]` and `pulse[i]` change together at edge E0+`SYNC_STAGES`+`DB_CYCLES`-1.
- The pulse width is exactly 1 cycle.
- Back-to-back events on one channel are at least `DB_CYCLES` cycles apart.

## Configuration
- **`KEY_AUTOREPEAT_EN` defined:** each channel has a repeat counter, active while `level[i]==0` and `edge_mode` is 00 or 10.
  - The counter starts at the press-commit edge.
  - The first repeat pulse occurs `REP_DELAY` cycles after the press pulse.
  - Further repeat pulses follow every `REP_PERIOD` cycles.
  - Release, a mode leaving 00/10, or reset clears the counter immediately, with no further repeats.
  - A repeat pulse coinciding with a commit edge is merged into a single 1-cycle pulse.
- **`KEY_AUTOREPEAT_EN` undefined:** no repeat logic is built. `REP_DELAY` and `REP_PERIOD` are ignored, and the port list is unchanged.

## Test plan
Bench configuration: `CH`=4, `SYNC_STAGES`=2, `DB_CYCLES`=8, `REP_DELAY`=20, `REP_PERIOD`=5.

1. Reset, then `key[0]` 1→0 held, mode 00 → `level[0]` falls and `pulse[0]` is high for one cycle at E0+9. `any_pulse` is high in that same cycle. Other channels stay quiet.
2. `key[1]` low for 7 cycles then high, mode 10 → no change on `level[1]` and no pulse.
3. Mode 01: press then release `key[2]` → no pulse on the press. One pulse on the release at E0+9 of the rising edge. Repeat with mode 11 → no pulses, and `level` still tracks the key.
4. `key[0]` and `key[3]` fall on the same cycle, mode 10 → `pulse` is 4'b1001 for exactly one cycle.
5. `rst_n` asserted 5 cycles into a debounce interval → all outputs are immediately at their reset values. After release, the key still low → press pulse at `DB_CYCLES`+`SYNC_STAGES`-1 edges after the first post-reset sample.
6. With `KEY_AUTOREPEAT_EN`, hold `key[0]` low, mode 00 → pulses at commit, +20, +25, +30, … Release → repeats stop. Without the macro → only the commit pulse.
